// File: rtl/ram8_arb_pkg.sv
// Shared types and constants for the RAM8 two-requester arbiter.
package ram8_arb_pkg;

    localparam int WIDTH = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int REQ_A = 0;
    localparam int REQ_B = 1;

endpackage

// File: rtl/ram8_arb_rr2.sv
// Two-way request picker producing a one-hot grant.
// RAM8_ARB_FIXED_PRIO_EN selects fixed A-over-B priority instead of round-robin.
module ram8_arb_rr2
    import ram8_arb_pkg::*;
(
    input  logic [1:0] req,
`ifndef RAM8_ARB_FIXED_PRIO_EN
    input  logic       last,
`endif
    output logic [1:0] gnt
);

`ifdef RAM8_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt        = 2'b00;
        gnt[REQ_A] = req[REQ_A];
        gnt[REQ_B] = req[REQ_B] & ~req[REQ_A];
    end
`else
    // last = 1 means B was served most recently, so A wins a tie.
    always_comb begin
        gnt        = 2'b00;
        gnt[REQ_A] = req[REQ_A] & (~req[REQ_B] | last);
        gnt[REQ_B] = req[REQ_B] & (~req[REQ_A] | ~last);
    end
`endif

endmodule

// File: rtl/ram8_arbiter.sv
// Shares one 8x16 RAM8 between requesters A and B: init sweep after reset, then
// single-word accesses by round-robin (fixed priority with RAM8_ARB_FIXED_PRIO_EN).
module ram8_arbiter #(
    parameter int                 WIDTH      = 16,
    parameter int                 AW         = 3,
    parameter logic [WIDTH-1:0]   INIT_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_req,
    input  logic             a_we,
    input  logic [AW-1:0]    a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    output logic             a_gnt,
    output logic             a_rvalid,
    input  logic             b_req,
    input  logic             b_we,
    input  logic [AW-1:0]    b_addr,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             b_gnt,
    output logic             b_rvalid,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic [WIDTH-1:0] ram_in,
    output logic             ram_load,
    output logic [AW-1:0]    ram_address,
    input  logic [WIDTH-1:0] ram_out
);
    import ram8_arb_pkg::*;

    state_t          state, state_nxt;
    logic [AW-1:0]   init_addr;
    logic [1:0]      run_req;
    logic [1:0]      gnt;
`ifndef RAM8_ARB_FIXED_PRIO_EN
    logic            last;
`endif

    // Requests seen during the sweep are masked, never recorded.
    assign run_req = (state == ST_RUN) ? {b_req, a_req} : 2'b00;

    ram8_arb_rr2 u_pick (
        .req  (run_req),
`ifndef RAM8_ARB_FIXED_PRIO_EN
        .last (last),
`endif
        .gnt  (gnt)
    );

    assign a_gnt = gnt[REQ_A];
    assign b_gnt = gnt[REQ_B];

    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        ram_load    = 1'b0;
        ram_address = '0;
        ram_in      = '0;
        if (state == ST_INIT) begin
            busy        = 1'b1;
            ram_load    = 1'b1;
            ram_address = init_addr;
            ram_in      = INIT_VALUE;
            if (init_addr == {AW{1'b1}})
                state_nxt = ST_RUN;
        end else if (gnt[REQ_A]) begin
            ram_load    = a_we;
            ram_address = a_addr;
            ram_in      = a_wdata;
        end else if (gnt[REQ_B]) begin
            ram_load    = b_we;
            ram_address = b_addr;
            ram_in      = b_wdata;
        end
    end

    // Grant edge: RAM write lands, or read data is captured with a one-cycle valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_INIT;
            init_addr <= '0;
`ifndef RAM8_ARB_FIXED_PRIO_EN
            last      <= 1'b1;
`endif
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            rdata     <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT)
                init_addr <= init_addr + AW'(1);
`ifndef RAM8_ARB_FIXED_PRIO_EN
            if (|gnt)
                last <= gnt[REQ_B];
`endif
            a_rvalid <= gnt[REQ_A] & ~a_we;
            b_rvalid <= gnt[REQ_B] & ~b_we;
            if ((gnt[REQ_A] & ~a_we) | (gnt[REQ_B] & ~b_we))
                rdata <= ram_out;
        end
    end

endmodule

// File: tb/tb_ram8_arbiter.sv
// Bench for ram8_arbiter: RAM8 model, directed steps and random traffic against a reference model.
module tb_ram8_arbiter;
    localparam int WIDTH = 16;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             a_req, a_we, b_req, b_we;
    logic [AW-1:0]    a_addr, b_addr;
    logic [WIDTH-1:0] a_wdata, b_wdata;
    logic             a_gnt, a_rvalid, b_gnt, b_rvalid, busy, ram_load;
    logic [WIDTH-1:0] rdata, ram_in, ram_out;
    logic [AW-1:0]    ram_address;

    always #5 clk = ~clk;

    ram8_arbiter dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid),
        .rdata(rdata), .busy(busy),
        .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address),
        .ram_out(ram_out)
    );

    // c_RAM8 stand-in; fill preloads non-init garbage so a skipped sweep shows up.
    logic [WIDTH-1:0] ram [8];
    logic             fill;
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 8; i++) ram[i] <= 16'hDE00 + 16'(i);
        end else if (ram_load) begin
            ram[ram_address] <= ram_in;
        end
    end
    assign ram_out = ram[ram_address];

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int               init_left;
    logic             ref_last_b;
    logic [WIDTH-1:0] ref_mem [8];
    logic [WIDTH-1:0] exp_rdata;
    logic             exp_arv, exp_brv;
    logic             win_a, win_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: called just after a falling edge with inputs already set.
    task automatic cycle();
        #1;
        win_a = 1'b0;
        win_b = 1'b0;
        if (init_left > 0) begin
            check("busy_init", busy, 1);
            check("a_gnt_init", a_gnt, 0);
            check("b_gnt_init", b_gnt, 0);
            check("load_init", ram_load, 1);
            check("addr_init", ram_address, 32'(8 - init_left));
            check("in_init", ram_in, 0);
        end else begin
            check("busy_run", busy, 0);
            if (a_req && b_req) begin
`ifdef RAM8_ARB_FIXED_PRIO_EN
                win_a = 1'b1;
`else
                if (ref_last_b) win_a = 1'b1;
                else            win_b = 1'b1;
`endif
            end else begin
                win_a = a_req;
                win_b = b_req;
            end
            check("a_gnt", a_gnt, win_a);
            check("b_gnt", b_gnt, win_b);
            if (win_a) begin
                check("load_a", ram_load, a_we);
                check("addr_a", ram_address, a_addr);
                check("in_a", ram_in, a_wdata);
            end else if (win_b) begin
                check("load_b", ram_load, b_we);
                check("addr_b", ram_address, b_addr);
                check("in_b", ram_in, b_wdata);
            end else begin
                check("load_idle", ram_load, 0);
                check("addr_idle", ram_address, 0);
                check("in_idle", ram_in, 0);
            end
        end
        @(posedge clk);
        exp_arv = 1'b0;
        exp_brv = 1'b0;
        if (init_left > 0) begin
            ref_mem[8 - init_left] = 16'h0000;
            init_left--;
        end else if (win_a) begin
            ref_last_b = 1'b0;
            if (a_we) ref_mem[a_addr] = a_wdata;
            else begin exp_rdata = ref_mem[a_addr]; exp_arv = 1'b1; end
        end else if (win_b) begin
            ref_last_b = 1'b1;
            if (b_we) ref_mem[b_addr] = b_wdata;
            else begin exp_rdata = ref_mem[b_addr]; exp_brv = 1'b1; end
        end
        #1;
        check("a_rvalid", a_rvalid, exp_arv);
        check("b_rvalid", b_rvalid, exp_brv);
        check("rdata", rdata, exp_rdata);
        @(negedge clk);
    endtask

    task automatic access_a(input logic we, input logic [AW-1:0] addr, input logic [WIDTH-1:0] d);
        a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = d;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (win_a) break;
        end
        check("a_grant_timeout", win_a, 1);
        a_req = 1'b0;
    endtask

    task automatic access_b(input logic we, input logic [AW-1:0] addr, input logic [WIDTH-1:0] d);
        b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = d;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (win_b) break;
        end
        check("b_grant_timeout", win_b, 1);
        b_req = 1'b0;
    endtask

    task automatic model_reset();
        init_left  = 8;
        ref_last_b = 1'b1;
        exp_rdata  = '0;
        exp_arv    = 1'b0;
        exp_brv    = 1'b0;
    endtask

    initial begin
        fill = 1'b1;
        reset = 1'b1;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        win_a = 0; win_b = 0;
        for (int i = 0; i < 8; i++) ref_mem[i] = 'x;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        fill = 1'b0;
        check("rst_busy", busy, 1);
        check("rst_a_rvalid", a_rvalid, 0);
        check("rst_b_rvalid", b_rvalid, 0);
        check("rst_rdata", rdata, 0);

        // A requests throughout the sweep; first grant must be the first run cycle
        reset = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 3'd5;
        for (int i = 0; i < 8; i++) cycle();
        cycle();
        check("first_run_a_gnt", win_a, 1);
        a_req = 1'b0;

        for (int i = 0; i < 8; i++) access_a(1'b0, AW'(i), '0);

        access_a(1'b1, 3'd3, 16'hBEEF);
        access_a(1'b0, 3'd3, '0);
        check("beef_readback", rdata, 16'hBEEF);

        // Cross-requester read-after-write
        access_b(1'b1, 3'd7, 16'h1234);
        access_a(1'b0, 3'd7, '0);
        check("raw_readback", rdata, 16'h1234);

        // Contention with last = B: A, B, A, B (A always with fixed priority)
        access_b(1'b1, 3'd1, 16'h0101);
        a_req = 1'b1; a_we = 1'b0; a_addr = 3'd1;
        b_req = 1'b1; b_we = 1'b1; b_addr = 3'd2; b_wdata = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (win_a) a_addr = a_addr + 3'd1;
            if (win_b) begin b_addr = b_addr + 3'd1; b_wdata = b_wdata + 16'h1111; end
        end
        a_req = 1'b0; b_req = 1'b0;

        for (int c = 0; c < 300; c++) begin
            if (!a_req || win_a) begin
                a_req = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
                a_addr = AW'($urandom_range(0, 7)); a_wdata = WIDTH'($urandom);
            end
            if (!b_req || win_b) begin
                b_req = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
                b_addr = AW'($urandom_range(0, 7)); b_wdata = WIDTH'($urandom);
            end
            cycle();
        end
        a_req = 1'b0; b_req = 1'b0;

        access_a(1'b1, 3'd3, 16'hBEEF);
        // Reset lands in the same window as a granted read
        a_req = 1'b1; a_we = 1'b0; a_addr = 3'd3;
        #1;
        check("pre_rst_a_gnt", a_gnt, 1);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_a_rvalid", a_rvalid, 0);
        check("midrst_rdata", rdata, 0);
        check("midrst_busy", busy, 1);
        @(negedge clk);
        reset = 1'b0;
        a_req = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) cycle();
        for (int i = 0; i < 8; i++) access_a(1'b0, AW'(i), '0);
        access_b(1'b0, 3'd3, '0);
        check("post_sweep_word3", rdata, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ram8_arbiter.md
Name: ram8_arbiter

Overview:
- Controller and arbiter that shares one c_RAM8 instance (8 x 16-bit, clocked write, combinational read) between two requesters, A and B.
- After reset it runs an init sweep that writes INIT_VALUE to all 8 words, then grants single-word read/write accesses by round-robin.
- Sits between the RAM8 and its two clients and drives the RAM8's in/load/address pins.

Parameters:
- WIDTH, 16, data width; must match the RAM8 word.
- AW, 3, address width; depth = 2**AW = 8.
- INIT_VALUE, 16'h0000, value written to every word during the init sweep.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_req  in  1  requester A access request; held until granted.
- a_we  in  1  A: 1 = write, 0 = read; valid while a_req.
- a_addr  in  AW  A word address.
- a_wdata  in  WIDTH  A write data.
- a_gnt  out  1  A request accepted this cycle (combinational).
- a_rvalid  out  1  A read data valid (one cycle).
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid: same as the A ports, for requester B.
- rdata  out  WIDTH  registered read data, shared by both requesters; qualified by a_rvalid/b_rvalid.
- busy  out  1  high while the init sweep runs.
- ram_in  out  WIDTH  to RAM8 in.
- ram_load  out  1  to RAM8 load.
- ram_address  out  AW  to RAM8 address.
- ram_out  in  WIDTH  from RAM8 out.

Behaviour:
- Reset (async, any time, including mid-sweep or mid-access):
  - state = ST_INIT, init_addr = 0, last = B (so A wins the first tie).
  - a_rvalid = b_rvalid = 0, rdata = 0.
  - Pending reads are dropped. The sweep restarts on the first edge after reset deasserts.
- ST_INIT:
  - busy = 1, a_gnt = b_gnt = 0.
  - Drives ram_load = 1, ram_address = init_addr, ram_in = INIT_VALUE.
  - init_addr increments each edge. On the edge that writes address 7, go to ST_RUN.
  - Sweep takes exactly 8 cycles. busy falls in the 9th cycle after reset release.
- ST_RUN:
  - busy = 0.
  - Winner selection:
    - Only one req asserted: that requester wins.
    - Both asserted: the requester not equal to last wins.
  - Winner's gnt = 1 combinationally in the same cycle. The other gnt = 0. last is updated to the winner at the edge.
  - Winner drives ram_address = x_addr, ram_in = x_wdata, ram_load = x_we.
  - No req: ram_load = 0, ram_address = 0, ram_in = 0.
- Write latency: the word is updated at the granting edge; a read of it in the next cycle returns the new value.
- Read latency: at the granting edge, rdata <= ram_out and x_rvalid <= 1 for exactly one cycle.
- Back-to-back reads: one per cycle. rvalid pulses are pipelined and never overlap; rdata is held until the next read.
- Requester rules:
  - Holds req/we/addr/wdata stable until gnt.
  - May deassert req in the cycle after gnt, or keep it high for another access.
- Address wrap: none; AW bits fully span the depth.
- Requests made during ST_INIT are not granted or recorded. They are served in ST_RUN if still held.

Optional Feature:
- Macro: RAM8_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, A always beats B; last is unused and removed. B can starve under continuous a_req.
- Undefined (default): round-robin as above; worst-case wait is 1 cycle.

Decomposition:
- Package ram8_arb_pkg:
  - WIDTH/AW/DEPTH localparams.
  - State enum ST_INIT, ST_RUN.
  - Requester ids REQ_A = 0, REQ_B = 1.
- Sub-module ram8_arb_rr2: 2-way picker.
  - Inputs: req[1:0], last.
  - Outputs: one-hot gnt[1:0].
  - Contains the RAM8_ARB_FIXED_PRIO_EN switch.

Test Plan:
- Init sweep: release reset, poll -> busy high 8 cycles with ram_load = 1 and addresses 0..7 written with 0x0000; then reading each address returns 0x0000.
- Single write/read: a_req, a_we = 1, addr 3, data 0xBEEF; next cycle A reads addr 3 -> a_gnt same cycle, then a_rvalid = 1 one cycle later with rdata = 0xBEEF.
- Contention, round-robin: a_req and b_req held high for 4 cycles -> grants A, B, A, B. With RAM8_ARB_FIXED_PRIO_EN defined -> A, A, A, A.
- Cross-requester RAW: B writes 0x1234 to addr 7 in cycle n; A reads addr 7 in cycle n+1 -> rdata = 0x1234 with a_rvalid in cycle n+2.
- Reset mid-operation: assert reset on the same edge window as a granted read -> a_rvalid stays 0, busy re-rises, the sweep rewrites all 8 words to INIT_VALUE.
- Request during init: a_req held from reset release -> no a_gnt while busy; a_gnt in the first ST_RUN cycle.
